// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: opaque payload, valid/ready handshake, flush, NOP bubble, stall counter.
// Optional macro PIPE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE   = {DATA_W{1'b0}},
  parameter int                 STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_W-1:0]       r_main, w_main_nxt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    w_accept, w_consume, w_stall_inc;

  assign out_valid   = (r_state != S_EMPTY);
  assign out_data    = r_main;
  assign stall_cnt   = r_stall_cnt;
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = out_valid && out_ready;
  assign w_stall_inc = out_valid && !out_ready && !flush;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_skid, w_skid_nxt;
  logic              r_in_ready;

  assign in_ready = r_in_ready;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_main     <= NOP_VALUE;
`ifdef PIPE_SKID_EN
      r_skid     <= NOP_VALUE;
      r_in_ready <= 1'b1;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
`ifdef PIPE_SKID_EN
      r_skid     <= w_skid_nxt;
      // Registered "skid empty" breaks the consumer-to-producer ready path.
      r_in_ready <= (w_state_nxt != S_TWO);
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
`ifdef PIPE_SKID_EN
    w_skid_nxt  = r_skid;
`endif
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = NOP_VALUE;
`ifdef PIPE_SKID_EN
      w_skid_nxt  = NOP_VALUE;
`endif
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            w_main_nxt  = in_data;
          end else if (w_consume) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VALUE;
          end
`ifdef PIPE_SKID_EN
          else if (w_accept) begin
            w_state_nxt = S_TWO;
            w_skid_nxt  = in_data;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        S_TWO: begin
          if (w_consume) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP_VALUE;
          end
        end
`endif
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (stall_clr)
      r_stall_cnt <= '0;
    else if (w_stall_inc && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hA5A5_0013;
`ifdef PIPE_SKID_EN
  localparam int          CAP = 2;
`else
  localparam int          CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  int            m_cnt;

  pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .STALL_CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check_model();
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data",  out_data,  (q.size() > 0) ? q[0] : NOP);
    chk("in_ready",  in_ready,  m_ready());
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Check mid-cycle, then advance the model by one rising edge.
  task automatic tick();
    bit acc, con;
    @(negedge clk);
    check_model();
    acc = in_valid && m_ready();
    con = (q.size() > 0) && out_ready;
    if (stall_clr) m_cnt = 0;
    else if ((q.size() > 0) && !out_ready && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
    if (flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    m_cnt = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  NOP);
    chk("rst_ready", in_ready,  1);
    chk("rst_cnt",   stall_cnt, 0);
    @(posedge clk); #1;
    chk("rst_hold_data", out_data, NOP);
    rst = 1'b0;
    tick();
    chk("rst_release", out_data, 32'hDEADBEEF);

    // drain, then stream 1..4 back to back
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = k;
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data,  k);
    end
    in_valid = 1'b0;
    tick();

    // backpressure
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 1;
    tick();
    in_data = 2;
    for (int k = 0; k < 5; k++) tick();
    chk("bp_data", out_data, 1);
    chk("bp_cnt",  stall_cnt, 5);
`ifdef PIPE_SKID_EN
    chk("bp_ready", in_ready, 0);
    in_valid = 1'b0;
`endif
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_rel_data", out_data, 2);
    tick();

    // flush drops held entries and the offered C
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_data",  out_data,  NOP);
    tick(); tick();

    // saturation and clear priority
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_cnt", stall_cnt, 15);
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    chk("clr_cnt", stall_cnt, 0);
    out_ready = 1'b1; tick(); tick();

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      stall_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0; stall_clr = 1'b0;

    // asynchronous reset in the middle of a transfer
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data",  out_data,  NOP);
    chk("arst_ready", in_ready,  1);
    chk("arst_cnt",   stall_cnt, 0);
    q.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
